pipe_hazard_ctrl: RTL

- Central stall/flush controller for the 5-stage pipeline.
- Drives the pause/bubble pair of every pipeline register (if_id, id_ex, ex_mem, mem_wb) plus the PC hold.
- Resolves data-memory wait, multi-cycle mul/div occupancy of EX, EX-stage redirects, load-use hazards and instruction-fetch wait under one fixed priority.
- Tracks wrong-path fetch responses and counts stall cycles.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 25 ++
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl_md_timer.sv | 73 +++++++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: MD FSM encodings,
// register-index width and the load-use comparison helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned MD_CNT_W  = 8;

    localparam logic [1:0] MD_IDLE = 2'b00;
    localparam logic [1:0] MD_BUSY = 2'b01;
    localparam logic [1:0] MD_DONE = 2'b10;

    // x0 never carries a dependency, so a load targeting it cannot cause a stall
    function automatic logic load_use_hit(
        input logic                 ex_load,
        input logic [REG_IDX_W-1:0] ex_rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 rs1_used,
        input logic                 rs2_used
    );
        return ex_load && (ex_rd != 5'd0) &&
               ((rs1_used && (rs1 == ex_rd)) || (rs2_used && (rs2 == ex_rd)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline status inputs and stage control outputs of the hazard
// controller; master is the pipeline side, slave is the controller.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    import pipe_hazard_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_rs1_used;
    logic                 id_rs2_used;
    logic [REG_IDX_W-1:0] ex_rd;
    logic                 ex_load;
    logic                 ex_md;
    logic                 ex_redirect;
    logic                 if_ready;
    logic                 mem_req;
    logic                 mem_ready;

    logic                 pc_pause;
    logic                 if_id_pause;
    logic                 if_id_bubble;
    logic                 id_ex_pause;
    logic                 id_ex_bubble;
    logic                 ex_mem_pause;
    logic                 ex_mem_bubble;
    logic                 mem_wb_pause;
    logic                 mem_wb_bubble;
    logic                 md_busy;
    logic [CNT_W-1:0]     stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_load, ex_md,
               ex_redirect, if_ready, mem_req, mem_ready,
        input  pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
               ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
               md_busy, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_load, ex_md,
               ex_redirect, if_ready, mem_req, mem_ready,
        output pc_pause, if_id_pause, if_id_bubble, id_ex_pause, id_ex_bubble,
               ex_mem_pause, ex_mem_bubble, mem_wb_pause, mem_wb_bubble,
               md_busy, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md_timer.sv
// Occupancy timer for iterative mul/div in EX: keeps EX stalled so the op
// spends exactly MD_LATENCY cycles there, then parks in DONE until it leaves.
module pipe_md_timer
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clock,
    input  logic reset,
    input  logic ex_md,
    input  logic hold,
    output logic md_stall,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] CNT_LOAD = MD_CNT_W'(MD_LATENCY - 2);

    logic [1:0]          state_r;
    logic [1:0]          state_nxt_s;
    logic [MD_CNT_W-1:0] cnt_r;
    logic [MD_CNT_W-1:0] cnt_nxt_s;

    // Next state; the counter keeps running under hold, only the start and the
    // DONE->IDLE release wait for the memory stall to clear
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            MD_IDLE: begin
                if (ex_md && !hold) begin
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = (CNT_LOAD == {MD_CNT_W{1'b0}}) ? MD_DONE : MD_BUSY;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            MD_BUSY: begin
                cnt_nxt_s = cnt_r - MD_CNT_W'(1);
                if (cnt_r == MD_CNT_W'(1)) begin
                    state_nxt_s = MD_DONE;
                end else begin
                    state_nxt_s = MD_BUSY;
                end
            end
            MD_DONE: begin
                if (hold) begin
                    state_nxt_s = MD_DONE;
                end else begin
                    state_nxt_s = MD_IDLE;
                end
            end
            default: begin
                state_nxt_s = MD_IDLE;
                cnt_nxt_s   = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= MD_IDLE;
            cnt_r   <= {MD_CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign md_busy  = (state_r == MD_BUSY);
    assign md_stall = ((state_r == MD_IDLE) && ex_md) || md_busy;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: fixed-priority
// pause/bubble generation, wrong-path fetch tracking and stall-cycle counting.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int          XLEN       = 32,
    parameter int unsigned MD_LATENCY = 32,
    parameter int          CNT_W      = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    if ((MD_LATENCY < 2) || (MD_LATENCY > 256) || (XLEN < 1)) begin : g_param_check
        $error("pipe_hazard_ctrl: illegal parameter value");
    end

    logic             mem_stall_s;
    logic             md_stall_s;
    logic             md_busy_s;
    logic             load_use_s;
    logic             fetch_stall_s;
    logic             redirect_win_s;
    logic             drop_nxt_s;
    logic             drop_pending_r;
    logic [CNT_W-1:0] stall_cycles_r;

    pipe_md_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_timer (
        .clock    (clock),
        .reset    (reset),
        .ex_md    (hz.ex_md),
        .hold     (mem_stall_s),
        .md_stall (md_stall_s),
        .md_busy  (md_busy_s)
    );

    assign mem_stall_s    = hz.mem_req && !hz.mem_ready;
    assign load_use_s     = load_use_hit(hz.ex_load, hz.ex_rd, hz.id_rs1, hz.id_rs2,
                                         hz.id_rs1_used, hz.id_rs2_used);
    assign fetch_stall_s  = !hz.if_ready || drop_pending_r;
    assign redirect_win_s = hz.ex_redirect && !mem_stall_s && !md_stall_s;

    // A response arriving always retires the pending drop; a winning redirect
    // with no response this cycle marks the in-flight fetch as wrong-path
    assign drop_nxt_s = (redirect_win_s && !hz.if_ready) ? 1'b1 :
                        (hz.if_ready ? 1'b0 : drop_pending_r);

    // Fixed-priority pause/bubble mux: mem > mul/div > redirect > load-use > fetch
    always_comb begin
        hz.pc_pause      = 1'b0;
        hz.if_id_pause   = 1'b0;
        hz.if_id_bubble  = 1'b0;
        hz.id_ex_pause   = 1'b0;
        hz.id_ex_bubble  = 1'b0;
        hz.ex_mem_pause  = 1'b0;
        hz.ex_mem_bubble = 1'b0;
        hz.mem_wb_pause  = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        if (reset) begin
            hz.pc_pause      = 1'b1;
            hz.if_id_bubble  = 1'b1;
            hz.id_ex_bubble  = 1'b1;
            hz.ex_mem_bubble = 1'b1;
            hz.mem_wb_bubble = 1'b1;
        end else if (mem_stall_s) begin
            hz.pc_pause      = 1'b1;
            hz.if_id_pause   = 1'b1;
            hz.id_ex_pause   = 1'b1;
            hz.ex_mem_pause  = 1'b1;
            hz.mem_wb_bubble = 1'b1;
        end else if (md_stall_s) begin
            hz.pc_pause      = 1'b1;
            hz.if_id_pause   = 1'b1;
            hz.id_ex_pause   = 1'b1;
            hz.ex_mem_bubble = 1'b1;
        end else if (hz.ex_redirect) begin
            hz.if_id_bubble  = 1'b1;
            hz.id_ex_bubble  = 1'b1;
        end else if (load_use_s) begin
            hz.pc_pause      = 1'b1;
            hz.if_id_pause   = 1'b1;
            hz.id_ex_bubble  = 1'b1;
        end else if (fetch_stall_s) begin
            hz.pc_pause      = 1'b1;
            hz.if_id_bubble  = 1'b1;
        end else begin
            hz.pc_pause      = 1'b0;
        end
    end

    // Wrong-path fetch tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_pending_r <= 1'b0;
        end else begin
            drop_pending_r <= drop_nxt_s;
        end
    end

    // Saturating count of cycles with the PC held
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_r <= {CNT_W{1'b0}};
        end else if (hz.pc_pause && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign hz.md_busy      = md_busy_s;
    assign hz.stall_cycles = stall_cycles_r;

endmodule
